// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder between fetch and execute.
// Splits a raw instruction into rs1/rs2/fn/imm, classifies the operation, flags
// illegal encodings and sign-extends the immediate. A two-entry skid buffer
// (output register + skid register) sustains one bundle per cycle under
// backpressure; inReady depends only on registered state.
// Optional build macro DECODE_ILLEGAL_CNT_EN adds the saturating illegalCnt output.
module decode_stage #(
    parameter int unsigned INST_W = 8,
    parameter int unsigned REG_W  = 2,
    parameter int unsigned FN_W   = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     flush,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [INST_W-1:0]        instIn,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [REG_W-1:0]         rs1,
    output logic [REG_W-1:0]         rs2,
    output logic [FN_W-1:0]          fn,
    output logic [INST_W-FN_W-1:0]   imm,
    output logic [DATA_W-1:0]        immExt,
    output logic [2:0]               opClass,
    output logic                     altMode,
    output logic                     isBranch,
    output logic                     isMem,
    output logic                     illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0]         illegalCnt
`endif
);

    localparam int unsigned IMM_W = INST_W - FN_W;
    // rs1, rs2, fn, imm, immExt, opClass, altMode, isBranch, isMem, illegal
    localparam int unsigned BUN_W = 2 * REG_W + FN_W + IMM_W + DATA_W + 3 + 4;

    localparam logic [2:0] OpBlt   = 3'd1;
    localparam logic [2:0] OpLoad  = 3'd2;
    localparam logic [2:0] OpBeq   = 3'd5;
    localparam logic [2:0] OpStore = 3'd6;
    localparam logic [2:0] OpJump  = 3'd7;

    // Reject parameter sets whose fields cannot be carved out of the instruction.
    if (INST_W < 2 * REG_W + FN_W) begin : g_bad_inst_w
        $error("decode_stage: INST_W must be >= 2*REG_W + FN_W");
    end
    if (FN_W < 4) begin : g_bad_fn_w
        $error("decode_stage: FN_W must be >= 4");
    end
    if (DATA_W < IMM_W) begin : g_bad_data_w
        $error("decode_stage: DATA_W must be >= INST_W - FN_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("decode_stage: CNT_W must be >= 1");
    end

    logic [REG_W-1:0]  w_rs1;
    logic [REG_W-1:0]  w_rs2;
    logic [FN_W-1:0]   w_fn;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_imm_ext;
    logic [2:0]        w_op_class;
    logic              w_alt_mode;
    logic              w_illegal;
    logic              w_is_branch;
    logic              w_is_mem;
    logic [BUN_W-1:0]  w_bundle;

    logic              w_load_out;
    logic              w_accept;
    logic              w_consume;

    logic              r_out_valid;
    logic              r_skid_valid;
    logic [BUN_W-1:0]  r_out_bundle;
    logic [BUN_W-1:0]  r_skid_bundle;

    // Combinational decode of the incoming instruction.
    always_comb begin
        w_rs1      = instIn[INST_W-1 -: REG_W];
        w_rs2      = instIn[INST_W-1-REG_W -: REG_W];
        w_fn       = instIn[FN_W-1:0];
        w_imm      = instIn[INST_W-1:FN_W];
        w_imm_ext  = {DATA_W{w_imm[IMM_W-1]}};
        w_imm_ext[IMM_W-1:0] = w_imm;
        w_op_class = w_fn[2:0];
        w_alt_mode = w_fn[3];
        // fn = x111 with alt set has no meaning; wider fn fields reserve upper bits.
        w_illegal  = (w_fn[3:0] == 4'hF) || ((w_fn >> 4) != '0);
        w_is_branch = ((w_op_class == OpBlt) || (w_op_class == OpBeq) ||
                       (w_op_class == OpJump)) && !w_illegal;
        w_is_mem    = ((w_op_class == OpLoad) || (w_op_class == OpStore)) && !w_illegal;
        w_bundle    = {w_rs1, w_rs2, w_fn, w_imm, w_imm_ext, w_op_class,
                       w_alt_mode, w_is_branch, w_is_mem, w_illegal};
    end

    // Handshake terms: skid full blocks input, flush discards the input.
    always_comb begin
        w_load_out = !r_out_valid || outReady;
        w_accept   = inValid && !r_skid_valid && !flush;
        w_consume  = r_out_valid && outReady;
    end

    // Occupancy of the output and skid slots; flush empties both.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid  <= r_skid_valid || w_accept;
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Bundle data: output refills from skid first to keep FIFO order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_out_bundle  <= '0;
            r_skid_bundle <= '0;
        end else if (!flush) begin
            if (w_load_out) begin
                if (r_skid_valid) begin
                    r_out_bundle <= r_skid_bundle;
                end else if (w_accept) begin
                    r_out_bundle <= w_bundle;
                end
            end else if (w_accept) begin
                r_skid_bundle <= w_bundle;
            end
        end
    end

    assign inReady  = !r_skid_valid;
    assign outValid = r_out_valid;
    assign {rs1, rs2, fn, imm, immExt, opClass, altMode, isBranch, isMem, illegal} = r_out_bundle;

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] r_illegal_cnt;

    // Saturating count of consumed illegal bundles; only reset clears it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_illegal_cnt <= '0;
        end else if (w_consume && illegal && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign illegalCnt = r_illegal_cnt;
`else
    logic w_consume_unused;
    assign w_consume_unused = w_consume;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks from the test plan plus a
// randomized run scored against a queue-based model on every falling edge.
module tb_decode_stage;

    logic        clk;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [7:0]  instIn;
    logic        outValid;
    logic        outReady;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [3:0]  fn;
    logic [3:0]  imm;
    logic [15:0] immExt;
    logic [2:0]  opClass;
    logic        altMode;
    logic        isBranch;
    logic        isMem;
    logic        illegal;
    logic [7:0]  illegalCnt;

    // Second instance with wider fields.
    logic        flush_b;
    logic        inValid_b;
    logic        inReady_b;
    logic [11:0] instIn_b;
    logic        outValid_b;
    logic        outReady_b;
    logic [2:0]  rs1_b;
    logic [2:0]  rs2_b;
    logic [3:0]  fn_b;
    logic [7:0]  imm_b;
    logic [15:0] immExt_b;
    logic [2:0]  opClass_b;
    logic        altMode_b;
    logic        isBranch_b;
    logic        isMem_b;
    logic        illegal_b;
    logic [7:0]  illegalCnt_b;

    int checks;
    int errors;
    int q[$];
    int cnt_m;

    decode_stage #(
        .INST_W(8), .REG_W(2), .FN_W(4), .DATA_W(16), .CNT_W(8)
    ) dut (
        .clk(clk), .rstN(rstN), .flush(flush), .inValid(inValid), .inReady(inReady),
        .instIn(instIn), .outValid(outValid), .outReady(outReady), .rs1(rs1), .rs2(rs2),
        .fn(fn), .imm(imm), .immExt(immExt), .opClass(opClass), .altMode(altMode),
        .isBranch(isBranch), .isMem(isMem), .illegal(illegal)
`ifdef DECODE_ILLEGAL_CNT_EN
        , .illegalCnt(illegalCnt)
`endif
    );

    decode_stage #(
        .INST_W(12), .REG_W(3), .FN_W(4), .DATA_W(16), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rstN(rstN), .flush(flush_b), .inValid(inValid_b), .inReady(inReady_b),
        .instIn(instIn_b), .outValid(outValid_b), .outReady(outReady_b), .rs1(rs1_b),
        .rs2(rs2_b), .fn(fn_b), .imm(imm_b), .immExt(immExt_b), .opClass(opClass_b),
        .altMode(altMode_b), .isBranch(isBranch_b), .isMem(isMem_b), .illegal(illegal_b)
`ifdef DECODE_ILLEGAL_CNT_EN
        , .illegalCnt(illegalCnt_b)
`endif
    );

`ifndef DECODE_ILLEGAL_CNT_EN
    assign illegalCnt   = '0;
    assign illegalCnt_b = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a FIFO of at most two raw instructions; the head is
    // what the output shows, occupancy 2 means the skid slot is full.
    always @(negedge clk) begin : model
        int  h;
        int  f;
        int  oc;
        int  bad;
        bit  cons;
        bit  acc;
        if (!rstN) begin
            q.delete();
            cnt_m = 0;
        end
        chk("outValid", {31'd0, outValid}, (q.size() > 0) ? 1 : 0);
        chk("inReady", {31'd0, inReady}, (q.size() < 2) ? 1 : 0);
        if (q.size() > 0) begin
            h   = q[0];
            f   = h % 16;
            oc  = f % 8;
            bad = (f == 15) ? 1 : 0;
            chk("rs1", 32'(rs1), h / 64);
            chk("rs2", 32'(rs2), (h / 16) % 4);
            chk("fn", 32'(fn), f);
            chk("imm", 32'(imm), h / 16);
            chk("immExt", 32'(immExt), (h / 16 >= 8) ? 32'hFFF0 + h / 16 : h / 16);
            chk("opClass", 32'(opClass), oc);
            chk("altMode", 32'(altMode), f / 8);
            chk("illegal", 32'(illegal), bad);
            chk("isBranch", 32'(isBranch),
                ((oc == 1 || oc == 5 || oc == 7) && bad == 0) ? 1 : 0);
            chk("isMem", 32'(isMem), (oc == 2 || oc == 6) ? 1 : 0);
        end
`ifdef DECODE_ILLEGAL_CNT_EN
        chk("illegalCnt", 32'(illegalCnt), cnt_m);
`endif
        if (rstN) begin
            cons = (q.size() > 0) && outReady;
            acc  = inValid && (q.size() < 2) && !flush;
            if (cons && (q[0] % 16) == 15 && cnt_m < 255) cnt_m++;
            if (flush) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back(int'(instIn));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; instIn = '0;
        flush_b = 1'b0; inValid_b = 1'b0; outReady_b = 1'b0; instIn_b = '0;

        // Reset state.
        #12;
        chk("rst_outValid", {31'd0, outValid}, 0);
        chk("rst_inReady", {31'd0, inReady}, 1);
        chk("rst_bundle", {immExt, rs1, rs2, fn, imm, opClass, altMode, illegal}, 0);
        chk("rst_illegalCnt", 32'(illegalCnt), 0);
        #5;
        rstN = 1'b1;

        // Basic decode, plus the wide instance.
        instIn = 8'b10101011; inValid = 1'b1; outReady = 1'b1;
        instIn_b = 12'b011100001011; inValid_b = 1'b1; outReady_b = 1'b1;
        step();
        chk("t1_outValid", {31'd0, outValid}, 1);
        chk("t1_rs1", 32'(rs1), 32'b10);
        chk("t1_rs2", 32'(rs2), 32'b10);
        chk("t1_fn", 32'(fn), 32'b1011);
        chk("t1_opClass", 32'(opClass), 3);
        chk("t1_altMode", 32'(altMode), 1);
        chk("t1_imm", 32'(imm), 32'b1010);
        chk("t1_immExt", 32'(immExt), 32'hFFFA);
        chk("t1_illegal", 32'(illegal), 0);
        chk("t6_rs1", 32'(rs1_b), 32'b011);
        chk("t6_rs2", 32'(rs2_b), 32'b100);
        chk("t6_imm", 32'(imm_b), 32'h70);
        chk("t6_immExt", 32'(immExt_b), 32'h0070);
        chk("t6_opClass", 32'(opClass_b), 3);
        inValid_b = 1'b0;

        // Jump versus illegal encoding.
        instIn = 8'b10100111;
        step();
        chk("t2_jump_opClass", 32'(opClass), 7);
        chk("t2_jump_isBranch", 32'(isBranch), 1);
        chk("t2_jump_illegal", 32'(illegal), 0);
        instIn = 8'b10101111;
        step();
        chk("t2_ill_illegal", 32'(illegal), 1);
        chk("t2_ill_isBranch", 32'(isBranch), 0);
        inValid = 1'b0;
        step();
        chk("t2_drained", {31'd0, outValid}, 0);
`ifdef DECODE_ILLEGAL_CNT_EN
        chk("t2_illegalCnt", 32'(illegalCnt), 1);
`endif

        // Backpressure: A0 held, A1 skidded, A2 refused, then drained in order.
        outReady = 1'b0; inValid = 1'b1; instIn = 8'hA0;
        step();
        instIn = 8'hA1;
        step();
        instIn = 8'hA2;
        step();
        chk("t3_held", {imm, fn}, 32'hA0);
        chk("t3_inReady", {31'd0, inReady}, 0);
        outReady = 1'b1;
        step();
        chk("t3_second", {imm, fn}, 32'hA1);
        inValid = 1'b1;
        step();
        chk("t3_third", {imm, fn}, 32'hA2);
        inValid = 1'b0;
        step();
        chk("t3_empty", {31'd0, outValid}, 0);

        // Flush with both slots full and an input presented.
        outReady = 1'b0; inValid = 1'b1; instIn = 8'hA0;
        step();
        instIn = 8'hA1;
        step();
        chk("t4_full", {31'd0, inReady}, 0);
        flush = 1'b1; instIn = 8'hA4;
        step();
        chk("t4_outValid", {31'd0, outValid}, 0);
        chk("t4_inReady", {31'd0, inReady}, 1);
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_A4", {31'd0, outValid}, 0);
        end

        // Asynchronous reset mid-stream.
        outReady = 1'b0; inValid = 1'b1; instIn = 8'hA5;
        step();
        instIn = 8'hA6;
        step();
        inValid = 1'b0;
        #1 rstN = 1'b0;
        #1;
        chk("t5_outValid", {31'd0, outValid}, 0);
        chk("t5_inReady", {31'd0, inReady}, 1);
        chk("t5_bundle", {immExt, rs1, rs2, fn, imm, opClass}, 0);
        step();
        rstN = 1'b1;

        // Randomized traffic scored by the model.
        for (int i = 0; i < 6000; i++) begin
            inValid  = ($urandom % 4) != 0;
            outReady = ($urandom % 3) != 0;
            flush    = ($urandom % 20) == 0;
            instIn   = 8'($urandom);
            if ($urandom % 4 == 0) instIn[3:0] = 4'hF;
            step();
        end
        inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
